// File: rtl/pe_skew_feeder.sv
// Operand skew feeder for the PE array: per-lane delay chains diagonally skew
// each accepted K-slice, with a small IDLE/STREAM/FLUSH sequencer around them.
module pe_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [ROWS*DATA_WIDTH-1:0] a_in,
  input  logic [COLS*DATA_WIDTH-1:0] b_in,
  output logic [ROWS*DATA_WIDTH-1:0] a_skew,
  output logic [COLS*DATA_WIDTH-1:0] b_skew,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       k_count
);

  localparam int D  = ((ROWS > COLS) ? ROWS : COLS) - 1;
  localparam int FW = (D > 0) ? $clog2(D + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t                r_state;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_k_count;
  logic                  w_hs;

  assign in_ready = (r_state == S_STREAM);
  assign w_hs     = in_valid & in_ready;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign k_count  = r_k_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
      r_k_count   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_STREAM;
            r_k_count <= '0;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (r_k_count != {CNT_WIDTH{1'b1}}) r_k_count <= r_k_count + 1'b1;
            if (in_last) begin
              r_state     <= S_FLUSH;
              r_flush_cnt <= FW'(D);
              r_done      <= (D == 0);
            end
          end
        end
        S_FLUSH: begin
          // done is registered one cycle early so it lines up with flush_cnt==0
          if (r_flush_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
            r_done      <= (r_flush_cnt == FW'(1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_a_lane
      logic [DATA_WIDTH-1:0] r_pipe [0:gi];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s <= gi; s++) r_pipe[s] <= '0;
        end else begin
          r_pipe[0] <= w_hs ? a_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int s = 1; s <= gi; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end
      assign a_skew[gi*DATA_WIDTH +: DATA_WIDTH] = r_pipe[gi];
    end

    for (gi = 0; gi < COLS; gi++) begin : g_b_lane
      logic [DATA_WIDTH-1:0] r_pipe [0:gi];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s <= gi; s++) r_pipe[s] <= '0;
        end else begin
          r_pipe[0] <= w_hs ? b_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int s = 1; s <= gi; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end
      assign b_skew[gi*DATA_WIDTH +: DATA_WIDTH] = r_pipe[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Bench for pe_skew_feeder: directed and random streams compared every cycle
// against a cycle-indexed history of accepted beats and a stream-level model.
module tb_pe_skew_feeder;

  localparam int DW   = 8;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CW   = 16;
  localparam int D    = ((ROWS > COLS) ? ROWS : COLS) - 1;
  localparam int M_IDLE = 0, M_STREAM = 1, M_FLUSH = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [ROWS*DW-1:0]   a_in;
  logic [COLS*DW-1:0]   b_in;
  logic [ROWS*DW-1:0]   a_skew;
  logic [COLS*DW-1:0]   b_skew;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        k_count;

  pe_skew_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a_in(a_in), .b_in(b_in), .a_skew(a_skew), .b_skew(b_skew),
    .busy(busy), .done(done), .k_count(k_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: what was accepted in each cycle, plus stream-level state
  logic [63:0] hist_a [0:1023];
  logic [63:0] hist_b [0:1023];
  int m_cyc        = 0;
  int m_state      = M_IDLE;
  int m_k          = 0;
  int m_flush_end  = 0;
  int zero_before  = 0;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, m_cyc, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic iv, input logic il, input logic rs,
                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb;
    start = st; in_valid = iv; in_last = il; rst_n = rs;
    a_in = a[ROWS*DW-1:0]; b_in = b[COLS*DW-1:0];
    @(negedge clk);
    ea = '0; eb = '0;
    for (int i = 0; i < ROWS; i++) begin
      int idx;
      idx = m_cyc - 1 - i;
      if (idx >= zero_before) ea[i*DW +: DW] = hist_a[idx][i*DW +: DW];
    end
    for (int j = 0; j < COLS; j++) begin
      int idx;
      idx = m_cyc - 1 - j;
      if (idx >= zero_before) eb[j*DW +: DW] = hist_b[idx][j*DW +: DW];
    end
    chk("a_skew",   64'(a_skew),   ea);
    chk("b_skew",   64'(b_skew),   eb);
    chk("in_ready", 64'(in_ready), 64'(m_state == M_STREAM));
    chk("busy",     64'(busy),     64'(m_state != M_IDLE));
    chk("done",     64'(done),     64'(m_state == M_FLUSH && m_cyc == m_flush_end));
    chk("k_count",  64'(k_count),  64'(m_k));
    @(posedge clk);
    hist_a[m_cyc] = '0;
    hist_b[m_cyc] = '0;
    if (!rs) begin
      m_state     = M_IDLE;
      m_k         = 0;
      zero_before = m_cyc + 1;
    end else begin
      case (m_state)
        M_IDLE: if (st) begin m_state = M_STREAM; m_k = 0; end
        M_STREAM: if (iv) begin
          hist_a[m_cyc] = a;
          hist_b[m_cyc] = b;
          if (m_k < (1 << CW) - 1) m_k++;
          $display("beat cyc=%0d k=%0d last=%0b a=%h b=%h", m_cyc, m_k, il, a, b);
          if (il) begin m_state = M_FLUSH; m_flush_end = m_cyc + 1 + D; end
        end
        default: if (m_cyc == m_flush_end) m_state = M_IDLE;
      endcase
    end
    m_cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, 1'b1, rnd64(), rnd64());
  endtask

  initial begin
    clk = 0; rst_n = 0; start = 0; in_valid = 0; in_last = 0; a_in = '0; b_in = '0;
    @(posedge clk); #1;

    // reset with garbage inputs, start must be ignored
    step(1'b1, 1'b1, 1'b1, 1'b0, rnd64(), rnd64());
    step(1'b1, 1'b1, 1'b0, 1'b0, rnd64(), rnd64());
    // beats offered in IDLE are not taken
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());

    // single beat
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h0101010101010101, 64'h0202020202020202);
    idle(10);

    // three back-to-back beats
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'h1111111111111111, 64'hFFFFFFFFFFFFFFFF);
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'h2222222222222222, 64'hFEFEFEFEFEFEFEFE);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h3333333333333333, 64'hFDFDFDFDFDFDFDFD);
    idle(11);

    // bubble between two beats
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd64(), rnd64());
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());
    idle(11);

    // reset two cycles after the last beat
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, rnd64(), rnd64());
    idle(10);

    // start during STREAM and FLUSH (including the done cycle), valid in FLUSH/IDLE
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    step(1'b1, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());
    for (int c = 0; c < D + 1; c++) step(1'b1, 1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    idle(3);

    // random streams with random bubbles and stray starts
    for (int s = 0; s < 6; s++) begin
      int len;
      len = $urandom_range(1, 7);
      step(1'b1, 1'b0, 1'b0, 1'b1, rnd64(), rnd64());
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 2) == 0)
          step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1, rnd64(), rnd64());
        step(1'($urandom_range(0, 1)), 1'b1, (k == len - 1), 1'b1, rnd64(), rnd64());
      end
      idle($urandom_range(D + 2, D + 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
